// File: rtl/serial_arith_pkg.sv
// ============================================================================
//  Module   : serial_arith_pkg
//  Purpose  : Shared state encoding and single-bit subtract helper for the
//             bit-serial arithmetic blocks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {borrow, diff} for x - y - r.
    function automatic logic [1:0] fs_bit(input logic x, input logic y, input logic r);
        logic d;
        logic bo;
        d  = x ^ y ^ r;
        bo = (~x & y) | (~(x ^ y) & r);
        return {bo, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
//  Module   : full_subtractor
//  Purpose  : Combinational one-bit full subtractor (a - b - borrow_in).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module full_subtractor
    import serial_arith_pkg::*;
(
    output logic diff,
    output logic borrow_out,
    input  logic a,
    input  logic b,
    input  logic borrow_in
);

    assign {borrow_out, diff} = fs_bit(a, b, borrow_in);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial W-bit subtractor, LSB first, with start/busy/done
//             handshake and registered diff, borrow and signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out,
    output logic         ovf
);

    localparam int             CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [W-1:0]   diff_sh_q, diff_sh_d;
    logic [CW-1:0]  count_q, count_d;
    logic           borrow_q, borrow_d;
    logic           a_msb_q, a_msb_d;
    logic           b_msb_q, b_msb_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           borrow_out_q, borrow_out_d;
    logic           ovf_q, ovf_d;

    logic           fs_diff;
    logic           fs_borrow;

    full_subtractor u_fs (
        .diff       (fs_diff),
        .borrow_out (fs_borrow),
        .a          (a_sh_q[0]),
        .b          (b_sh_q[0]),
        .borrow_in  (borrow_q)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        diff_sh_d    = diff_sh_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        ovf_d        = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    borrow_d  = borrow_in;
                    a_msb_d   = a[W-1];
                    b_msb_d   = b[W-1];
                    diff_sh_d = '0;
                    count_d   = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                diff_sh_d = {fs_diff, diff_sh_q[W-1:1]};
                borrow_d  = fs_borrow;
                if (count_q == LAST) begin
                    // Final bit: commit the assembled word directly from this step.
                    diff_d       = {fs_diff, diff_sh_q[W-1:1]};
                    borrow_out_d = fs_borrow;
                    ovf_d        = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
                    state_d      = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            diff_sh_q    <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            diff_sh_q    <= diff_sh_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (W=4) against an
//             integer-arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.W(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction and signed range test.
    task automatic ref_model(input int av, input int bv, input int bin,
                             output logic [W-1:0] ed, output logic eb, output logic eo);
        int full;
        int sa;
        int sb;
        int sr;
        full = av - bv - bin;
        ed   = W'((full + (4 << W)) % (1 << W));
        eb   = (av < (bv + bin));
        sa   = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb   = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        sr   = sa - sb - bin;
        eo   = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 4 * W) begin
            @(posedge clk); #1;
            g++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bin, input string tag);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           edges;
        logic         busy_ok;
        wait_idle();
        @(negedge clk);
        a = av; b = bv; borrow_in = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
        edges   = 1;
        busy_ok = busy;
        while (!done && edges < 4 * W) begin
            @(posedge clk); #1;
            edges++;
            if (!busy) busy_ok = 1'b0;
        end
        ref_model(int'(av), int'(bv), int'(bin), ed, eb, eo);
        check({tag, "_latency"}, 32'(edges), 32'(W + 1));
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           n_done;
        int           g;
        logic [W-1:0] seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Directed cases and boundaries.
        run_op(4'd9, 4'd3, 1'b0, "d_9m3");
        run_op(4'd3, 4'd9, 1'b0, "d_3m9");
        run_op(4'd0, 4'd0, 1'b1, "d_0m0b");
        run_op(4'd8, 4'd1, 1'b0, "d_8m1");
        run_op(4'd5, 4'd5, 1'b0, "d_eq");
        wait_idle();
        check("hold_diff_idle", 32'(diff), 32'd0);

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
        end

        // start re-asserted mid-run must be ignored.
        wait_idle();
        @(negedge clk);
        a = 4'd5; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 4'd14; b = 4'd1; borrow_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        seen   = '0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin
                n_done++;
                seen = diff;
            end
            @(posedge clk); #1;
        end
        check("ign_done_count", 32'(n_done), 32'd1);
        check("ign_diff", 32'(seen), 32'd3);

        // start held high: back-to-back op accepted in the idle cycle.
        wait_idle();
        @(negedge clk);
        a = 4'd6; b = 4'd1; borrow_in = 1'b1; start = 1'b1;
        g = 0;
        @(posedge clk); #1;
        while (!done && g < 4 * W) begin
            @(posedge clk); #1;
            g++;
        end
        ref_model(6, 1, 1, ed, eb, eo);
        check("b2b_first_diff", 32'(diff), 32'(ed));
        a = 4'd2; b = 4'd7; borrow_in = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("b2b_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        g = 0;
        while (!done && g < 4 * W) begin
            @(posedge clk); #1;
            g++;
        end
        ref_model(2, 7, 0, ed, eb, eo);
        check("b2b_second_diff", 32'(diff), 32'(ed));
        check("b2b_second_borrow", 32'(borrow_out), 32'(eb));
        check("b2b_second_ovf", 32'(ovf), 32'(eo));

        // Reset in the third RUN cycle abandons the run.
        run_op(4'd9, 4'd3, 1'b0, "pre_rst");
        wait_idle();
        @(negedge clk);
        a = 4'd7; b = 4'd2; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_borrow", 32'(borrow_out), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        n_done = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("mid_rst_no_done", 32'(n_done), 32'd0);
        run_op(4'd7, 4'd2, 1'b0, "post_rst");

        // Exhaustive sweep.
        for (int ia = 0; ia < (1 << W); ia++) begin
            for (int ib = 0; ib < (1 << W); ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(W'(ia), W'(ib), 1'(ic), "sweep");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor that computes diff = a - b - borrow_in, one bit per clock, LSB first.
- Built around a single-bit full-subtractor cell that is the subtract-direction counterpart of the team's full adder.
- Accepts operands with a start/busy/done handshake and returns a registered difference, a final borrow and a signed-overflow flag.
- Used in datapaths where area matters more than latency.

Parameters:
- W, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while idle
- a  input  W  minuend; captured on the accepted start
- b  input  W  subtrahend; captured on the accepted start
- borrow_in  input  1  initial borrow; captured on the accepted start
- busy  output  1  high from the cycle after acceptance until done is asserted (inclusive)
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on
- diff  output  W  result a - b - borrow_in, modulo 2^W
- borrow_out  output  1  final borrow (1 means the unsigned result went negative)
- ovf  output  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset: state goes to IDLE; busy, done, diff, borrow_out and ovf all 0; internal shift registers, count and borrow register cleared. Reset wins over all other inputs, including mid-operation. A run in progress is abandoned and no done pulse is produced.
- FSM states and transitions:
  - IDLE: on start=1, latch a, b and borrow_in; set count to 0; go to RUN. If start=0, stay in IDLE.
  - RUN: process one bit per cycle. When count==W-1, go to DONE; otherwise increment count.
  - DONE: assert done for one cycle; go to IDLE unconditionally.
- Bit step in RUN, with x = a_sh[0], y = b_sh[0], r = borrow register:
  - d = x ^ y ^ r
  - bnext = (~x & y) | (~(x ^ y) & r)
  - d shifts into the MSB of the diff shift register; a_sh and b_sh shift right; r <= bnext.
- Result commit: diff, borrow_out and ovf are updated at the RUN->DONE edge and held stable until the next commit or reset.
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the latched a and b.
  - borrow_in has no effect on the ovf formula beyond its effect on diff.
- Latency: with start accepted at edge k, done is high in the cycle following edge k+W+... precisely, state is DONE after edge k+W. Throughput is one operation per W+2 cycles.
- busy is high in the RUN and DONE states.
- start asserted in RUN or DONE is ignored, not queued. start held high continuously restarts immediately on return to IDLE.
- Operand inputs may change freely after the acceptance edge; only the latched copies are used.
- Width rules:
  - All internal registers are W bits wide; count is $clog2(W) bits wide.
  - No wrap-around on count: it never exceeds W-1.
- Boundaries:
  - a==b with borrow_in=0 gives diff=0, borrow_out=0.
  - a==0, b==0, borrow_in=1 gives diff=all ones, borrow_out=1.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a function computing the single-bit difference/borrow, for reuse in bench reference models.
- One sub-module, full_subtractor, with ports (diff, borrow_out, a, b, borrow_in) in the same output-first order as the team's full adder. It is purely combinational and is instantiated once in the datapath.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- W=4, a=9, b=3, borrow_in=0, start pulse -> done exactly W+1 edges after acceptance; diff=6, borrow_out=0, ovf=1 (signed -7 - 3 = -10 is out of range; result 6).
- W=4, a=3, b=9, borrow_in=0 -> diff=4'hA, borrow_out=1, ovf=1.
- W=4, a=0, b=0, borrow_in=1 -> diff=4'hF, borrow_out=1, ovf=0. Also a=8, b=1 -> diff=7, ovf=1, borrow_out=0.
- Pulse start again in the 2nd RUN cycle with different operands -> ignored; the result matches the first operands and only one done pulse occurs. With start held high, a back-to-back op begins the cycle after DONE.
- Assert rst in the 3rd RUN cycle -> next cycle busy=0, done=0, diff=0, borrow_out=0, ovf=0. No done appears for 2W cycles; a fresh start then completes correctly.
- Exhaustive W=4 sweep over all a, b and borrow_in (512 ops) against the reference (a - b - borrow_in) mod 16, with borrow = (a < b + borrow_in) and the signed-overflow check. The bench also checks that busy/done timing is identical for every op.
